msf_bit_decoder: RTL and testbench
==================================

MSF_BIT_DECODER -- requirements
Module: msf_bit_decoder

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 SHALL have port clk_i, input, 1 bit: system clock.
REQ-003 SHALL have port rst_ni, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port tick_i, input, 1 bit: single-cycle 100 Hz strobe (one tick = 10 ms).
REQ-005 SHALL have port msf_i, input, 1 bit: raw, asynchronous receiver output; 1 = carrier off.
REQ-006 SHALL have port bits_valid_o, output, 1 bit: one-cycle pulse per decoded second.
REQ-007 SHALL have port bits_is_second_00_o, output, 1 bit: decoded second is the minute marker; qualified by bits_valid_o.
REQ-008 SHALL have port bits_data_o, output, 2 bits: {B, A} data bits; qualified by bits_valid_o.
REQ-009 SHALL have port sync_o, output, 1 bit: level, high while second framing is locked.

Function
REQ-010 SHALL pass msf_i through a 2-flop synchronizer; all logic uses the synchronized value (msf_s).
REQ-011 SHALL define a second-start edge as msf_s 0->1 relative to its previous-cycle value.
REQ-012 SHALL implement states IDLE, MEASURE and GAP, with an 8-bit tick counter cnt.
REQ-013 SHALL, in IDLE, hold cnt and go to MEASURE with cnt=0 on an edge.
REQ-014 SHALL, in MEASURE and GAP, increment cnt on each tick_i.
REQ-015 SHALL give an edge priority over a tick in the same cycle: cnt=0 and that tick is ignored.
REQ-016 SHALL, in MEASURE at the tick making cnt=5, return to IDLE with no pulse if msf_s=0 (glitch).
REQ-017 SHALL, in MEASURE, latch A=msf_s at cnt=15, B=msf_s at cnt=25 and M=msf_s at cnt=45.
REQ-018 SHALL, in MEASURE at the tick making cnt=50, select one of three cases and go to GAP:
- M=0: pulse with data={B,A}, second_00=0.
- M=1 and A=B=1: pulse with data=2'b00, second_00=1.
- M=1 and A or B = 0: no pulse.
REQ-019 SHALL register the pulse and data so they are valid in the cycle after the qualifying tick; data and second_00 hold until the next pulse.
REQ-020 SHALL ignore edges in MEASURE, and in GAP while cnt<90.
REQ-021 SHALL, in GAP, go to MEASURE with cnt=0 on an edge while cnt>=90.
REQ-022 SHALL, in GAP, go to IDLE and clear sync_o when cnt reaches 150 with no edge.
REQ-023 SHALL set sync_o on every emitted pulse; a glitch abort does not change sync_o.
REQ-024 SHALL saturate cnt, never wrapping it (max used value 150).

Reset
REQ-025 SHALL, while rst_ni=0 at a clock edge, set state=IDLE, cnt=0, synchronizer flops=0, A/B/M=0 and all outputs=0.
REQ-026 SHALL, when reset asserts mid-MEASURE, emit no pulse for the interrupted second.
REQ-027 SHALL NOT treat the first cycle after reset release as an edge unless msf_s actually rises.

Structure
REQ-028 SHALL place the following constants in shared package msf_pkg:
- MSF_T_CHECK=5, MSF_T_A=15, MSF_T_B=25, MSF_T_M=45, MSF_T_EMIT=50.
- MSF_T_GAP_MIN=90, MSF_T_TIMEOUT=150.
- Counter width 8.
REQ-029 SHALL use a single sub-module, msf_sync, containing the 2-flop synchronizer plus previous-value register and rise output.

Verification
REQ-030 SHALL cover a normal second with carrier off 0-100 ms, on 100-200, off 200-300, on after -> one pulse at ~500 ms with data=2'b10, second_00=0, sync_o=1.
REQ-031 SHALL cover a minute marker with carrier off 0-500 ms -> one pulse, second_00=1, data=2'b00.
REQ-032 SHALL cover a 30 ms off glitch -> no pulse; state returns to IDLE; sync_o unchanged.
REQ-033 SHALL cover an extra edge at 600 ms and a true edge at 1000 ms -> the 600 ms edge is ignored; the next second decodes normally.
REQ-034 SHALL cover 60 consecutive seconds (marker then 59 data seconds), then carrier held on for 2 s -> exactly 60 pulses; sync_o falls 1.5 s after the last second start.
REQ-035 SHALL cover reset asserted at 300 ms into a second, with edge and tick coinciding after release -> no pulse for that second; the coincident edge starts MEASURE with cnt=0.

Source files
------------

// File: rtl/msf_bit_decoder_pkg.sv
// Shared constants for the MSF time-signal bit decoder.
// Holds the tick counts (10 ms each, measured from a second-start edge) at
// which the decoder checks, samples and emits, the counter width, the FSM
// state encodings, and a saturating increment helper.
package msf_pkg;

  localparam int CNT_W       = 8;
  localparam int MSF_DATA_W  = 2;

  localparam logic [CNT_W-1:0] MSF_T_CHECK   = 8'd5;
  localparam logic [CNT_W-1:0] MSF_T_A       = 8'd15;
  localparam logic [CNT_W-1:0] MSF_T_B       = 8'd25;
  localparam logic [CNT_W-1:0] MSF_T_M       = 8'd45;
  localparam logic [CNT_W-1:0] MSF_T_EMIT    = 8'd50;
  localparam logic [CNT_W-1:0] MSF_T_GAP_MIN = 8'd90;
  localparam logic [CNT_W-1:0] MSF_T_TIMEOUT = 8'd150;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/msf_bit_decoder_if.sv
// Signal bundle around the MSF bit decoder.
//   tick, msf          : 100 Hz strobe and raw receiver output (into decoder)
//   bits_valid         : one-cycle pulse per decoded second
//   bits_is_second_00  : decoded second was the minute marker
//   bits_data          : {B, A} data bits
//   sync               : second framing locked
// The master side drives tick/msf; the slave side is the decoder.
interface msf_bit_decoder_if;
  import msf_pkg::*;

  logic                  tick;
  logic                  msf;
  logic                  bits_valid;
  logic                  bits_is_second_00;
  logic [MSF_DATA_W-1:0] bits_data;
  logic                  sync;

  modport master (
    output tick, msf,
    input  bits_valid, bits_is_second_00, bits_data, sync
  );

  modport slave (
    input  tick, msf,
    output bits_valid, bits_is_second_00, bits_data, sync
  );

endinterface

// File: rtl/msf_bit_decoder_sync.sv
// Two-flop synchronizer for the asynchronous MSF receiver output, plus a
// previous-value register used to detect the carrier-off (0->1) transition
// that marks the start of each second.
//   clk_i, rst_ni : clock and synchronous active-low reset
//   async_i       : raw receiver output
//   level_o       : synchronized level (msf_s)
//   rise_o        : high for one cycle when level_o has just gone 0->1
module msf_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic meta;
  logic level;
  logic prev;

  // Everything clears on reset so a line that is already high is only seen
  // as a rise once the synchronized value actually climbs from the cleared 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= async_i;
      level <= meta;
      prev  <= level;
    end
  end

  assign level_o = level;
  assign rise_o  = level & ~prev;

endmodule

// File: rtl/msf_bit_decoder.sv
// MSF time-signal bit decoder. Frames each second from the carrier-off
// edge, rejects short glitches, samples the A, B and marker bits at fixed
// tick offsets and emits one pulse per decoded second.
//   clk_i, rst_ni       : clock and synchronous active-low reset
//   tick_i              : single-cycle 100 Hz strobe (10 ms)
//   msf_i               : raw receiver output, 1 = carrier off
//   bits_valid_o        : one-cycle pulse per decoded second
//   bits_is_second_00_o : minute marker flag, qualified by bits_valid_o
//   bits_data_o         : {B, A}, qualified by bits_valid_o
//   sync_o              : high while second framing is locked
module msf_bit_decoder
  import msf_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tick_i,
  input  logic                  msf_i,
  output logic                  bits_valid_o,
  output logic                  bits_is_second_00_o,
  output logic [MSF_DATA_W-1:0] bits_data_o,
  output logic                  sync_o
);

  logic             msf_s;
  logic             rise;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             bit_a;
  logic             bit_b;
  logic             bit_m;

  msf_sync u_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (msf_i),
    .level_o (msf_s),
    .rise_o  (rise)
  );

  assign cnt_nxt = cnt_inc(cnt);

  // Edges are only honoured in IDLE and late in GAP; when honoured they win
  // over a coincident tick, restarting the count at zero. During MEASURE the
  // line toggles with data, so only ticks advance the state there.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      bit_a               <= 1'b0;
      bit_b               <= 1'b0;
      bit_m               <= 1'b0;
      bits_valid_o        <= 1'b0;
      bits_is_second_00_o <= 1'b0;
      bits_data_o         <= '0;
      sync_o              <= 1'b0;
    end else begin
      bits_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_MEASURE;
            cnt   <= '0;
          end
        end

        ST_MEASURE: begin
          if (tick_i) begin
            cnt <= cnt_nxt;
            // Carrier already back on this early means it was a glitch.
            if (cnt_nxt == MSF_T_CHECK && !msf_s) state <= ST_IDLE;
            if (cnt_nxt == MSF_T_A) bit_a <= msf_s;
            if (cnt_nxt == MSF_T_B) bit_b <= msf_s;
            if (cnt_nxt == MSF_T_M) bit_m <= msf_s;
            if (cnt_nxt == MSF_T_EMIT) begin
              state <= ST_GAP;
              // Off through 450 ms only happens on the 500 ms minute marker,
              // which must also be off at the A and B sample points.
              if (!bit_m) begin
                bits_valid_o        <= 1'b1;
                bits_is_second_00_o <= 1'b0;
                bits_data_o         <= {bit_b, bit_a};
                sync_o              <= 1'b1;
              end else if (bit_a && bit_b) begin
                bits_valid_o        <= 1'b1;
                bits_is_second_00_o <= 1'b1;
                bits_data_o         <= 2'b00;
                sync_o              <= 1'b1;
              end
            end
          end
        end

        ST_GAP: begin
          if (rise && cnt >= MSF_T_GAP_MIN) begin
            state <= ST_MEASURE;
            cnt   <= '0;
          end else if (tick_i) begin
            cnt <= cnt_nxt;
            // No second start for 1.5 s: framing is lost.
            if (cnt_nxt == MSF_T_TIMEOUT) begin
              state  <= ST_IDLE;
              sync_o <= 1'b0;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msf_bit_decoder.sv
// Self-checking bench for msf_bit_decoder. A behavioural model derives the
// expected outputs from the sampled line level and tick counts since the
// last accepted second start; every cycle the DUT outputs are compared with
// it. Hand-computed checks pin pulse counts, decoded data and sync timing.
module tb_msf_bit_decoder;
  import msf_pkg::*;

  localparam int TICK_CYCLES = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;
  int   dut_pulses  = 0;

  msf_bit_decoder_if bus ();

  always #5 clk = ~clk;

  msf_bit_decoder dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .tick_i              (bus.tick),
    .msf_i               (bus.msf),
    .bits_valid_o        (bus.bits_valid),
    .bits_is_second_00_o (bus.bits_is_second_00),
    .bits_data_o         (bus.bits_data),
    .sync_o              (bus.sync)
  );

  // Behavioural model. hist holds the raw line as sampled on the last three
  // edges; the decoder sees it two edges late. since counts ticks from the
  // accepted second start (-1 = no second in progress); samples taken during
  // the first 500 ms are kept and judged together at 500 ms.
  bit       hist [3];
  int       since = -1;
  bit       decided;
  bit       samp [0:50];
  bit       m_level, m_prev, m_rise;
  bit       exp_valid, exp_sec00, exp_sync;
  bit [1:0] exp_data;
  bit       model_ready = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) hist[i] = 1'b0;
      since     = -1;
      decided   = 1'b0;
      exp_valid = 1'b0;
      exp_sec00 = 1'b0;
      exp_sync  = 1'b0;
      exp_data  = 2'b00;
    end else begin
      m_level   = hist[1];
      m_prev    = hist[2];
      m_rise    = m_level && !m_prev;
      exp_valid = 1'b0;
      if (since < 0) begin
        if (m_rise) begin
          since   = 0;
          decided = 1'b0;
        end
      end else if (!decided) begin
        if (bus.tick) begin
          since++;
          samp[since] = m_level;
          if (since == 5 && !m_level) begin
            since = -1;
          end else if (since == 50) begin
            decided = 1'b1;
            if (!samp[45]) begin
              exp_valid = 1'b1;
              exp_data  = {samp[25], samp[15]};
              exp_sec00 = 1'b0;
              exp_sync  = 1'b1;
            end else if (samp[15] && samp[25]) begin
              exp_valid = 1'b1;
              exp_data  = 2'b00;
              exp_sec00 = 1'b1;
              exp_sync  = 1'b1;
            end
          end
        end
      end else begin
        if (m_rise && since >= 90) begin
          since   = 0;
          decided = 1'b0;
        end else if (bus.tick) begin
          since++;
          if (since == 150) begin
            since    = -1;
            exp_sync = 1'b0;
          end
        end
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = bus.msf;
    end
    model_ready = 1'b1;
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_ready) begin
      vectors++;
      if (bus.bits_valid !== exp_valid || bus.bits_is_second_00 !== exp_sec00 ||
          bus.bits_data !== exp_data || bus.sync !== exp_sync) begin
        miscompares++;
        $display("[TB] FAIL cycle_compare t=%0t got v=%b s00=%b d=%b sync=%b want v=%b s00=%b d=%b sync=%b",
                 $time, bus.bits_valid, bus.bits_is_second_00, bus.bits_data, bus.sync,
                 exp_valid, exp_sec00, exp_data, exp_sync);
      end
      if (bus.bits_valid === 1'b1) dut_pulses++;
    end
  end

  task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Hold the line at one level for n tick periods; tick fires on the last
  // cycle of each period.
  task automatic apply_stimulus(input bit level, input int n);
    for (int t = 0; t < n; t++) begin
      for (int c = 0; c < TICK_CYCLES; c++) begin
        @(posedge clk);
        #1;
        bus.msf  = level;
        bus.tick = (c == TICK_CYCLES - 1);
      end
    end
  endtask

  // Off 0-100 ms, A level 100-200, B level 200-300, on for the rest.
  task automatic data_second(input bit a, input bit b);
    apply_stimulus(1'b1, 10);
    apply_stimulus(a, 10);
    apply_stimulus(b, 10);
    apply_stimulus(1'b0, 70);
  endtask

  task automatic marker_second();
    apply_stimulus(1'b1, 50);
    apply_stimulus(1'b0, 50);
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.msf  = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", {7'd0, bus.bits_valid}, 8'd0);
    check_output("reset_sync", {7'd0, bus.sync}, 8'd0);
    check_output("reset_data", {6'd0, bus.bits_data}, 8'd0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 5);

    // Normal second: A=0, B=1.
    data_second(1'b0, 1'b1);
    check_output("normal_pulses", dut_pulses[7:0], 8'd1);
    check_output("normal_data", {6'd0, bus.bits_data}, 8'd2);
    check_output("normal_sec00", {7'd0, bus.bits_is_second_00}, 8'd0);
    check_output("normal_sync", {7'd0, bus.sync}, 8'd1);

    // Minute marker.
    marker_second();
    check_output("marker_pulses", dut_pulses[7:0], 8'd2);
    check_output("marker_sec00", {7'd0, bus.bits_is_second_00}, 8'd1);
    check_output("marker_data", {6'd0, bus.bits_data}, 8'd0);

    // 30 ms glitch: no pulse, sync stays high.
    apply_stimulus(1'b1, 3);
    apply_stimulus(1'b0, 97);
    check_output("glitch_pulses", dut_pulses[7:0], 8'd2);
    check_output("glitch_sync", {7'd0, bus.sync}, 8'd1);

    // Second with a stray edge at 600 ms, then a true second at 1000 ms.
    apply_stimulus(1'b1, 10);
    apply_stimulus(1'b0, 10);
    apply_stimulus(1'b1, 10);
    apply_stimulus(1'b0, 30);
    apply_stimulus(1'b1, 2);
    apply_stimulus(1'b0, 38);
    data_second(1'b1, 1'b0);
    check_output("stray_pulses", dut_pulses[7:0], 8'd4);
    check_output("stray_data", {6'd0, bus.bits_data}, 8'd1);

    // A full minute, then carrier held on.
    marker_second();
    for (int i = 1; i < 60; i++) data_second(i[0], i[1]);
    check_output("minute_pulses", dut_pulses[7:0], 8'd64);
    check_output("minute_last_data", {6'd0, bus.bits_data}, 8'd3);
    apply_stimulus(1'b0, 45);
    check_output("sync_before_timeout", {7'd0, bus.sync}, 8'd1);
    apply_stimulus(1'b0, 10);
    check_output("sync_after_timeout", {7'd0, bus.sync}, 8'd0);
    apply_stimulus(1'b0, 145);

    // Reset 300 ms into a second, then an edge coinciding with a tick.
    apply_stimulus(1'b1, 10);
    apply_stimulus(1'b0, 10);
    apply_stimulus(1'b1, 10);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    bus.msf  = 1'b0;
    bus.tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("midreset_sync", {7'd0, bus.sync}, 8'd0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 3);
    check_output("midreset_pulses", dut_pulses[7:0], 8'd64);
    @(posedge clk); #1; bus.msf = 1'b1; bus.tick = 1'b0;
    @(posedge clk); #1; bus.tick = 1'b0;
    @(posedge clk); #1; bus.tick = 1'b1;
    @(posedge clk); #1; bus.tick = 1'b0;
    apply_stimulus(1'b1, 49);
    apply_stimulus(1'b0, 50);
    check_output("after_reset_pulses", dut_pulses[7:0], 8'd65);
    check_output("after_reset_sec00", {7'd0, bus.bits_is_second_00}, 8'd1);
    apply_stimulus(1'b0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
